// File: rtl/ariane_pkg.sv
// Shared execute-stage types: transaction IDs, exceptions and result-buffer entries.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned NR_WB_PORTS   = 4;
  localparam int unsigned WB_PORT_BITS  = $clog2(NR_WB_PORTS);

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [63:0] result;
    exception_t  ex;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_buffer.sv
// In-order result buffer: grants transaction IDs, collects out-of-order
// writebacks and presents them for commit in allocation order.
module wb_result_buffer
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 2**TRANS_ID_BITS
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic                                        alloc_valid_i,
  output logic                                        alloc_ready_o,
  output logic [TRANS_ID_BITS-1:0]                    alloc_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]                wb_ex_i,
  output logic                                        commit_valid_o,
  output logic [TRANS_ID_BITS-1:0]                    commit_trans_id_o,
  output logic [63:0]                                 commit_result_o,
  output exception_t                                  commit_ex_o,
  input  logic                                        commit_ack_i,
  output logic                                        wb_error_o
);

  localparam int unsigned IDW   = TRANS_ID_BITS;
  localparam int unsigned PW    = WB_PORT_BITS;
  localparam int unsigned CNT_W = TRANS_ID_BITS + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NR_ENTRIES);
  localparam logic [NR_WB_PORTS-1:0] PORT_ONE = NR_WB_PORTS'(1);

  wb_entry_t              entries_q [NR_ENTRIES];
  wb_entry_t              entries_d [NR_ENTRIES];
  logic [IDW-1:0]         head_q, head_d;
  logic [IDW-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wb_error_q, wb_error_d;
  logic                   wb_err;
  logic                   do_alloc, do_commit;
  logic [NR_WB_PORTS-1:0] hits;
  logic [PW-1:0]          win;

  // Lowest-index port wins when several ports target the same entry.
  function automatic logic [PW-1:0] lowest_port(input logic [NR_WB_PORTS-1:0] req);
    lowest_port = '0;
    for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
      if (req[PW'(p)]) lowest_port = PW'(p);
    end
  endfunction

  assign alloc_ready_o     = (cnt_q != FULL);
  assign alloc_trans_id_o  = tail_q;
  assign do_alloc          = alloc_valid_i & alloc_ready_o;
  assign do_commit         = commit_valid_o & commit_ack_i;

  // Commit view comes from stored state only; no bypass from the writeback ports.
  assign commit_valid_o    = entries_q[head_q].busy & entries_q[head_q].done;
  assign commit_trans_id_o = head_q;
  assign commit_result_o   = entries_q[head_q].result;
  assign commit_ex_o       = entries_q[head_q].ex;
  assign wb_error_o        = wb_error_q;

  // Next-state: writeback, allocation, commit; flush overrides all of them.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    wb_err    = 1'b0;
    hits      = '0;
    win       = '0;

    if (flush_i) begin
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        entries_d[IDW'(e)].busy = 1'b0;
        entries_d[IDW'(e)].done = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        hits = '0;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
          hits[PW'(p)] = wb_valid_i[PW'(p)] && (wb_trans_id_i[PW'(p)] == IDW'(e));
        end
        if (hits != '0) begin
          if (entries_q[IDW'(e)].busy && !entries_q[IDW'(e)].done) begin
            win                         = lowest_port(hits);
            entries_d[IDW'(e)].done     = 1'b1;
            entries_d[IDW'(e)].result   = wb_result_i[win];
            entries_d[IDW'(e)].ex       = wb_ex_i[win];
          end else begin
            wb_err = 1'b1;
          end
          if ((hits & (hits - PORT_ONE)) != '0) wb_err = 1'b1;
        end
      end

      // Head entry is done and the tail entry is free, so these never collide with the writes above.
      if (do_commit) begin
        entries_d[head_q].busy = 1'b0;
        entries_d[head_q].done = 1'b0;
        head_d                 = head_q + IDW'(1);
      end
      if (do_alloc) begin
        entries_d[tail_q].busy     = 1'b1;
        entries_d[tail_q].done     = 1'b0;
        entries_d[tail_q].ex.valid = 1'b0;
        tail_d                     = tail_q + IDW'(1);
      end

      if (do_alloc && !do_commit) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!do_alloc && do_commit) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    wb_error_d = wb_error_q | wb_err;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        entries_q[IDW'(e)] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      wb_error_q <= 1'b0;
    end else begin
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        entries_q[IDW'(e)] <= entries_d[IDW'(e)];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      wb_error_q <= wb_error_d;
    end
  end

endmodule

// File: tb/tb_wb_result_buffer.sv
// Directed self-checking bench for wb_result_buffer.
module tb_wb_result_buffer;
  import ariane_pkg::*;

  logic                                      clk_i = 1'b0;
  logic                                      rst_ni;
  logic                                      flush_i;
  logic                                      alloc_valid_i;
  logic                                      alloc_ready_o;
  logic [TRANS_ID_BITS-1:0]                  alloc_trans_id_o;
  logic [NR_WB_PORTS-1:0]                    wb_valid_i;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i;
  logic [NR_WB_PORTS-1:0][63:0]              wb_result_i;
  exception_t [NR_WB_PORTS-1:0]              wb_ex_i;
  logic                                      commit_valid_o;
  logic [TRANS_ID_BITS-1:0]                  commit_trans_id_o;
  logic [63:0]                               commit_result_o;
  exception_t                                commit_ex_o;
  logic                                      commit_ack_i;
  logic                                      wb_error_o;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_result_buffer dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .alloc_valid_i     (alloc_valid_i),
    .alloc_ready_o     (alloc_ready_o),
    .alloc_trans_id_o  (alloc_trans_id_o),
    .wb_valid_i        (wb_valid_i),
    .wb_trans_id_i     (wb_trans_id_i),
    .wb_result_i       (wb_result_i),
    .wb_ex_i           (wb_ex_i),
    .commit_valid_o    (commit_valid_o),
    .commit_trans_id_o (commit_trans_id_o),
    .commit_result_o   (commit_result_o),
    .commit_ex_o       (commit_ex_o),
    .commit_ack_i      (commit_ack_i),
    .wb_error_o        (wb_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i       = 1'b0;
    alloc_valid_i = 1'b0;
    commit_ack_i  = 1'b0;
    wb_valid_i    = '0;
    wb_trans_id_i = '0;
    wb_result_i   = '0;
    wb_ex_i       = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
  endtask

  task automatic set_wb(input int port, input logic [TRANS_ID_BITS-1:0] id,
                        input logic [63:0] res);
    wb_valid_i[port]    = 1'b1;
    wb_trans_id_i[port] = id;
    wb_result_i[port]   = res;
  endtask

  task automatic alloc_n(input int n);
    alloc_valid_i = 1'b1;
    repeat (n) cycle();
    alloc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %0h want 1", alloc_ready_o); end
    n_cmp++; if (alloc_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL reset_alloc_id: got %0d want 0", alloc_trans_id_o); end
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid: got %0h want 0", commit_valid_o); end
    n_cmp++; if (commit_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL reset_commit_id: got %0d want 0", commit_trans_id_o); end
    n_cmp++; if (commit_result_o !== 64'd0) begin n_fail++; $display("FAIL reset_commit_result: got %0h want 0", commit_result_o); end
    n_cmp++; if (commit_ex_o !== '0) begin n_fail++; $display("FAIL reset_commit_ex: got %0h want 0", commit_ex_o); end
    n_cmp++; if (wb_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_error: got %0h want 0", wb_error_o); end
  endtask

  task automatic test_fill();
    do_reset();
    alloc_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0h want 1", i, alloc_ready_o); end
      n_cmp++; if (alloc_trans_id_o !== 3'(i)) begin n_fail++; $display("FAIL fill_id[%0d]: got %0d want %0d", i, alloc_trans_id_o, i); end
      cycle();
    end
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %0h want 0", alloc_ready_o); end
    cycle();
    alloc_valid_i = 1'b0;
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ninth_ready: got %0h want 0", alloc_ready_o); end
    n_cmp++; if (alloc_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL fill_ninth_tail: got %0d want 0", alloc_trans_id_o); end
  endtask

  // Continues from the full buffer left by test_fill.
  task automatic test_simultaneous();
    set_wb(0, 3'd0, 64'h55);
    cycle();
    clear_inputs();
    n_cmp++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL sim_head_valid: got %0h want 1", commit_valid_o); end
    n_cmp++; if (commit_result_o !== 64'h55) begin n_fail++; $display("FAIL sim_head_result: got %0h want 55", commit_result_o); end
    commit_ack_i  = 1'b1;
    alloc_valid_i = 1'b1;
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL sim_ready_during_ack: got %0h want 0", alloc_ready_o); end
    cycle();
    clear_inputs();
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL sim_ready_after: got %0h want 1", alloc_ready_o); end
    n_cmp++; if (commit_trans_id_o !== 3'd1) begin n_fail++; $display("FAIL sim_head_adv: got %0d want 1", commit_trans_id_o); end
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL sim_commit_valid: got %0h want 0", commit_valid_o); end
    n_cmp++; if (alloc_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL sim_tail_wrap: got %0d want 0", alloc_trans_id_o); end
    alloc_n(1);
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL sim_refull_ready: got %0h want 0", alloc_ready_o); end
    n_cmp++; if (alloc_trans_id_o !== 3'd1) begin n_fail++; $display("FAIL sim_refull_tail: got %0d want 1", alloc_trans_id_o); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc_n(3);
    set_wb(2, 3'd2, 64'h22);
    cycle();
    clear_inputs();
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL ooo_no_early_commit: got %0h want 0", commit_valid_o); end
    set_wb(1, 3'd0, 64'h00);
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL ooo_no_bypass: got %0h want 0", commit_valid_o); end
    cycle();
    clear_inputs();
    n_cmp++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL ooo_latency: got %0h want 1", commit_valid_o); end
    set_wb(0, 3'd1, 64'h11);
    cycle();
    clear_inputs();
    commit_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL ooo_valid[%0d]: got %0h want 1", k, commit_valid_o); end
      n_cmp++; if (commit_trans_id_o !== 3'(k)) begin n_fail++; $display("FAIL ooo_id[%0d]: got %0d want %0d", k, commit_trans_id_o, k); end
      n_cmp++; if (commit_result_o !== 64'(k * 8'h11)) begin n_fail++; $display("FAIL ooo_result[%0d]: got %0h want %0h", k, commit_result_o, k * 8'h11); end
      cycle();
    end
    commit_ack_i = 1'b0;
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL ooo_drained: got %0h want 0", commit_valid_o); end
    n_cmp++; if (commit_trans_id_o !== 3'd3) begin n_fail++; $display("FAIL ooo_head_end: got %0d want 3", commit_trans_id_o); end
    n_cmp++; if (wb_error_o !== 1'b0) begin n_fail++; $display("FAIL ooo_no_error: got %0h want 0", wb_error_o); end
  endtask

  task automatic test_bad_wb();
    do_reset();
    set_wb(2, 3'd6, 64'h66);
    cycle();
    clear_inputs();
    n_cmp++; if (wb_error_o !== 1'b1) begin n_fail++; $display("FAIL bad_not_busy_err: got %0h want 1", wb_error_o); end
    do_reset();
    alloc_n(1);
    set_wb(0, 3'd0, 64'h1);
    cycle();
    clear_inputs();
    n_cmp++; if (wb_error_o !== 1'b0) begin n_fail++; $display("FAIL bad_first_wb_ok: got %0h want 0", wb_error_o); end
    set_wb(1, 3'd0, 64'h2);
    cycle();
    clear_inputs();
    n_cmp++; if (commit_result_o !== 64'h1) begin n_fail++; $display("FAIL bad_done_kept: got %0h want 1", commit_result_o); end
    n_cmp++; if (wb_error_o !== 1'b1) begin n_fail++; $display("FAIL bad_done_err: got %0h want 1", wb_error_o); end
  endtask

  task automatic test_port_conflict();
    do_reset();
    alloc_n(5);
    set_wb(1, 3'd4, 64'hA);
    set_wb(3, 3'd4, 64'hB);
    cycle();
    clear_inputs();
    n_cmp++; if (wb_error_o !== 1'b1) begin n_fail++; $display("FAIL conf_err: got %0h want 1", wb_error_o); end
    for (int p = 0; p < 4; p++) set_wb(p, 3'(p), 64'h100 + 64'(p));
    cycle();
    clear_inputs();
    commit_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (commit_result_o !== 64'h100 + 64'(k)) begin n_fail++; $display("FAIL conf_multi[%0d]: got %0h want %0h", k, commit_result_o, 64'h100 + 64'(k)); end
      cycle();
    end
    n_cmp++; if (commit_trans_id_o !== 3'd4) begin n_fail++; $display("FAIL conf_head: got %0d want 4", commit_trans_id_o); end
    n_cmp++; if (commit_result_o !== 64'hA) begin n_fail++; $display("FAIL conf_winner: got %0h want a", commit_result_o); end
    cycle();
    commit_ack_i = 1'b0;
    n_cmp++; if (wb_error_o !== 1'b1) begin n_fail++; $display("FAIL conf_sticky: got %0h want 1", wb_error_o); end
  endtask

  task automatic test_exception();
    do_reset();
    alloc_n(3);
    set_wb(0, 3'd0, 64'h5);
    set_wb(1, 3'd1, 64'h6);
    set_wb(3, 3'd2, 64'h7);
    wb_ex_i[3].valid = 1'b1;
    wb_ex_i[3].cause = 64'd2;
    cycle();
    clear_inputs();
    n_cmp++; if (commit_ex_o.valid !== 1'b0) begin n_fail++; $display("FAIL ex_head0_clean: got %0h want 0", commit_ex_o.valid); end
    commit_ack_i = 1'b1;
    repeat (2) cycle();
    commit_ack_i = 1'b0;
    n_cmp++; if (commit_trans_id_o !== 3'd2) begin n_fail++; $display("FAIL ex_head: got %0d want 2", commit_trans_id_o); end
    n_cmp++; if (commit_ex_o.valid !== 1'b1) begin n_fail++; $display("FAIL ex_valid: got %0h want 1", commit_ex_o.valid); end
    n_cmp++; if (commit_ex_o.cause !== 64'd2) begin n_fail++; $display("FAIL ex_cause: got %0h want 2", commit_ex_o.cause); end
    n_cmp++; if (commit_result_o !== 64'h7) begin n_fail++; $display("FAIL ex_result: got %0h want 7", commit_result_o); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(5);
    set_wb(0, 3'd0, 64'h9);
    cycle();
    clear_inputs();
    n_cmp++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %0h want 1", commit_valid_o); end
    flush_i       = 1'b1;
    alloc_valid_i = 1'b1;
    commit_ack_i  = 1'b1;
    set_wb(0, 3'd1, 64'h8);
    cycle();
    clear_inputs();
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_commit_valid: got %0h want 0", commit_valid_o); end
    n_cmp++; if (alloc_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL flush_tail: got %0d want 0", alloc_trans_id_o); end
    n_cmp++; if (commit_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL flush_head: got %0d want 0", commit_trans_id_o); end
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0h want 1", alloc_ready_o); end
    alloc_n(7);
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_cnt7_ready: got %0h want 1", alloc_ready_o); end
    alloc_n(1);
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_cnt8_ready: got %0h want 0", alloc_ready_o); end
  endtask

  // Continues from the full buffer left by test_flush.
  task automatic test_async_reset();
    set_wb(0, 3'd0, 64'h77);
    cycle();
    clear_inputs();
    n_cmp++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %0h want 1", commit_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_commit_valid: got %0h want 0", commit_valid_o); end
    n_cmp++; if (commit_result_o !== 64'd0) begin n_fail++; $display("FAIL arst_commit_result: got %0h want 0", commit_result_o); end
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0h want 1", alloc_ready_o); end
    n_cmp++; if (alloc_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL arst_tail: got %0d want 0", alloc_trans_id_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();
  endtask

  initial begin
    rst_ni = 1'b1;
    clear_inputs();
    test_reset();
    test_fill();
    test_simultaneous();
    test_out_of_order();
    test_bad_wb();
    test_port_conflict();
    test_exception();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
